fp_result_collector: RTL and testbench



---
 rtl/fp_result_collector.sv | 125 ++++++++++++
 tb/tb_fp_result_collector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_collector.sv
// Result FIFO behind the float add/sub unit: edge-captures each new result and serves it to a host.
// Optional sticky status accumulation is enabled by defining FP_STICKY_FLAGS_EN.
module fp_result_collector #(
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned DROP_W = 8,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock_100kHz,
  input  logic              reset,
  input  logic [31:0]       data_in,
  input  logic [3:0]        status_in,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic [3:0]        rd_status,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic [DROP_W-1:0] drop_cnt
`ifdef FP_STICKY_FLAGS_EN
  ,
  input  logic              clear_sticky,
  output logic [3:0]        sticky_flags
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [0:0] WAIT_CLR = 1'b0;
  localparam logic [0:0] ARMED    = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [35:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, full_q;
  logic [31:0]       rd_data_q;
  logic [3:0]        rd_status_q;
  logic              rd_valid_q;
  logic [DROP_W-1:0] drop_cnt_q;

  logic capture, rd_acc, wr_acc, drop;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      WAIT_CLR: if (status_in == 4'd0) state_d = ARMED;
      ARMED: begin
        if (status_in != 4'd0) begin
          capture = 1'b1;
          state_d = WAIT_CLR;
        end
      end
      default: state_d = WAIT_CLR;
    endcase
  end

  // A full FIFO still accepts a write when the same cycle frees a slot.
  always_comb begin
    rd_acc  = rd_en && !empty_q;
    wr_acc  = capture && (!full_q || rd_acc);
    drop    = capture && full_q && !rd_acc;
    count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  always_ff @(posedge clock_100kHz) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {status_in, data_in};
  end

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_CLR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      rd_data_q   <= '0;
      rd_status_q <= '0;
      rd_valid_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CNT_W'(DEPTH));
      rd_valid_q <= rd_acc;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        rd_data_q   <= mem_q[rd_ptr_q][31:0];
        rd_status_q <= mem_q[rd_ptr_q][35:32];
      end
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_status = rd_status_q;
  assign rd_valid  = rd_valid_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef FP_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  // Dropped captures still contribute; a clear coinciding with a capture keeps only that status.
  always_comb begin
    sticky_d = sticky_q;
    if (clear_sticky) sticky_d = capture ? status_in : 4'd0;
    else if (capture) sticky_d = sticky_q | status_in;
  end

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed self-checking bench for fp_result_collector (DEPTH=8, DROP_W=8).
`timescale 1ns/1ps
module tb_fp_result_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic [3:0]  status_in;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [3:0]  rd_status;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;
`ifdef FP_STICKY_FLAGS_EN
  logic        clear_sticky;
  logic [3:0]  sticky_flags;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_d [10];
  logic [3:0]  exp_s [10];

  always #5 clk = ~clk;

  fp_result_collector #(.DEPTH(8), .DROP_W(8)) dut (
    .clock_100kHz(clk),
    .reset       (rst_n),
    .data_in     (data_in),
    .status_in   (status_in),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_status   (rd_status),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .drop_cnt    (drop_cnt)
`ifdef FP_STICKY_FLAGS_EN
    ,
    .clear_sticky(clear_sticky),
    .sticky_flags(sticky_flags)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture event followed by a status-clear cycle that re-arms the FSM.
  task automatic capture(input logic [31:0] d, input logic [3:0] s);
    data_in   = d;
    status_in = s;
    tick();
    status_in = 4'd0;
    tick();
  endtask

  task automatic test_reset();
    data_in = 32'h0; status_in = 4'd0; rd_en = 1'b0; rst_n = 1'b0;
`ifdef FP_STICKY_FLAGS_EN
    clear_sticky = 1'b0;
`endif
    tick(); tick();
    n_cmp++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
      n_bad++; $display("FAIL por_flags: empty=%b full=%b count=%0d want 1 0 0", empty, full, count);
    end
    rst_n = 1'b1;
    tick();
    capture(32'h3F000000, 4'b0001);
    capture(32'h3F800000, 4'b0001);
    capture(32'h40000000, 4'b0001);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++;
    if (rd_data !== 32'h3F000000) begin
      n_bad++; $display("FAIL pre_reset_read: got %h want 3f000000", rd_data);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (empty !== 1'b1 || count !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 32'h0 ||
        drop_cnt !== 8'd0 || full !== 1'b0) begin
      n_bad++;
      $display("FAIL midstream_reset: empty=%b count=%0d rd_valid=%b rd_data=%h drop=%0d full=%b want 1 0 0 0 0 0",
               empty, count, rd_valid, rd_data, drop_cnt, full);
    end
    status_in = 4'b0001;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL stale_status: count=%0d empty=%b want 0 1", count, empty);
    end
    status_in = 4'd0;
    tick();
  endtask

  task automatic test_single();
    data_in = 32'h41000000; status_in = 4'b0001;
    repeat (5) tick();
    status_in = 4'd0;
    tick();
    n_cmp++;
    if (count !== 4'd1 || empty !== 1'b0) begin
      n_bad++; $display("FAIL held_status_count: count=%0d empty=%b want 1 0", count, empty);
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h41000000 || rd_status !== 4'b0001) begin
      n_bad++; $display("FAIL single_read: valid=%b data=%h status=%b want 1 41000000 0001",
                        rd_valid, rd_data, rd_status);
    end
    tick();
    n_cmp++;
    if (rd_valid !== 1'b0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL valid_pulse: valid=%b empty=%b want 0 1", rd_valid, empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      exp_d[i] = 32'h3E000000 + 32'(i) * 32'h02000000;
      exp_s[i] = 4'(1 << (i % 4));
      capture(exp_d[i], exp_s[i]);
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 4'd8 || drop_cnt !== 8'd2 || empty !== 1'b0) begin
      n_bad++; $display("FAIL overflow_state: full=%b count=%0d drop=%0d empty=%b want 1 8 2 0",
                        full, count, drop_cnt, empty);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d[i] || rd_status !== exp_s[i]) begin
        n_bad++; $display("FAIL order_read%0d: valid=%b data=%h status=%b want 1 %h %b",
                          i, rd_valid, rd_data, rd_status, exp_d[i], exp_s[i]);
      end
    end
    rd_en = 1'b0;
    tick();
    n_cmp++;
    if (empty !== 1'b1 || count !== 4'd0 || rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL drained: empty=%b count=%0d valid=%b want 1 0 0", empty, count, rd_valid);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = 32'h50000000 + 32'(i);
      capture(exp_d[i], 4'b1000);
    end
    data_in = 32'hC1000000; status_in = 4'b0010; rd_en = 1'b1;
    tick();
    status_in = 4'd0; rd_en = 1'b0;
    n_cmp++;
    if (count !== 4'd8 || full !== 1'b1 || drop_cnt !== 8'd2 || rd_valid !== 1'b1 || rd_data !== 32'h50000000) begin
      n_bad++; $display("FAIL full_rw: count=%0d full=%b drop=%0d valid=%b data=%h want 8 1 2 1 50000000",
                        count, full, drop_cnt, rd_valid, rd_data);
    end
    tick();
    exp_d[8] = 32'hC1000000;
    rd_en = 1'b1;
    for (int i = 1; i < 9; i++) begin
      tick();
      n_cmp++;
      if (rd_data !== exp_d[i]) begin
        n_bad++; $display("FAIL full_rw_read%0d: got %h want %h", i, rd_data, exp_d[i]);
      end
    end
    rd_en = 1'b0;
    tick();
    n_cmp++;
    if (rd_status !== 4'b0010 || empty !== 1'b1) begin
      n_bad++; $display("FAIL full_rw_last: status=%b empty=%b want 0010 1", rd_status, empty);
    end
  endtask

  task automatic test_empty_read();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 32'hC1000000 || count !== 4'd0) begin
      n_bad++; $display("FAIL empty_read: valid=%b data=%h count=%0d want 0 c1000000 0",
                        rd_valid, rd_data, count);
    end
  endtask

  task automatic test_back_to_back();
    data_in = 32'h42000000; status_in = 4'b0100; rd_en = 1'b1;
    tick();
    status_in = 4'd0; rd_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || count !== 4'd1 || empty !== 1'b0) begin
      n_bad++; $display("FAIL empty_rw: valid=%b count=%0d empty=%b want 0 1 0", rd_valid, count, empty);
    end
    tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h42000000 || rd_status !== 4'b0100) begin
      n_bad++; $display("FAIL empty_rw_read: valid=%b data=%h status=%b want 1 42000000 0100",
                        rd_valid, rd_data, rd_status);
    end
  endtask

`ifdef FP_STICKY_FLAGS_EN
  task automatic test_sticky();
    clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
    n_cmp++;
    if (sticky_flags !== 4'd0) begin
      n_bad++; $display("FAIL sticky_clear: got %b want 0000", sticky_flags);
    end
    capture(32'h7E000000, 4'b0010);
    capture(32'h3F000001, 4'b1000);
    n_cmp++;
    if (sticky_flags !== 4'b1010) begin
      n_bad++; $display("FAIL sticky_or: got %b want 1010", sticky_flags);
    end
    data_in = 32'h00000001; status_in = 4'b0100; clear_sticky = 1'b1;
    tick();
    status_in = 4'd0; clear_sticky = 1'b0;
    tick();
    n_cmp++;
    if (sticky_flags !== 4'b0100) begin
      n_bad++; $display("FAIL sticky_clear_capture: got %b want 0100", sticky_flags);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_rw();
    test_empty_read();
    test_back_to_back();
`ifdef FP_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
